// File: rtl/rv_pkg.sv
// Shared RV32I/Zicsr decode constants: major opcodes, immediate format codes
// and the default datapath width.
package rv_pkg;

  localparam int XLEN_DEF = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate format codes
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_Z = 3'd6;
  localparam logic [2:0] FMT_X = 3'd7;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational immediate decoder: instruction word in, XLEN-wide
// extended immediate, format code and illegal-opcode flag out.
module imm_decode
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  // Raw immediate fields, each held as a signed value so a size cast
  // replicates instr[31] up to whatever XLEN is.
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  logic        [4:0]  zimm;

  // funct3[1:0] never influences the immediate; only funct3[2] selects zimm.
  logic unused_funct3_lo;
  assign unused_funct3_lo = ^instr_i[13:12];

  assign imm_i = instr_i[31:20];
  assign imm_s = {instr_i[31:25], instr_i[11:7]};
  assign imm_b = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign zimm  = instr_i[19:15];

  // Opcode-driven format select and extension.
  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_X;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        imm_o = XLEN'(imm_i);
        fmt_o = FMT_I;
      end
      OPC_STORE: begin
        imm_o = XLEN'(imm_s);
        fmt_o = FMT_S;
      end
      OPC_BRANCH: begin
        imm_o = XLEN'(imm_b);
        fmt_o = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_o = XLEN'(imm_u);
        fmt_o = FMT_U;
      end
      OPC_JAL: begin
        imm_o = XLEN'(imm_j);
        fmt_o = FMT_J;
      end
      OPC_SYSTEM: begin
        // CSR*I forms carry a zero-extended 5-bit immediate in the rs1 field;
        // everything else in SYSTEM exposes the CSR address / ECALL field.
        if (instr_i[14]) begin
          imm_o = XLEN'(zimm);
          fmt_o = FMT_Z;
        end else begin
          imm_o = XLEN'(imm_i);
          fmt_o = FMT_I;
        end
      end
      OPC_OP: begin
        imm_o = '0;
        fmt_o = FMT_R;
      end
      default: begin
        imm_o     = '0;
        fmt_o     = FMT_X;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// ID-stage immediate generator: decodes the immediate of the current
// instruction and registers it into the ID/EX boundary with flush/stall/valid
// control. Outputs are driven only from registers.
module imm_gen_stage
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_fmt,
  output logic            illegal,
  output logic            out_valid
);

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  logic [XLEN-1:0] imm_q, imm_d;
  logic [2:0]      fmt_q, fmt_d;
  logic            illegal_q, illegal_d;
  logic            vld_q, vld_d;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i   (instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  // Next-state selection: flush beats stall beats load; bubbles only drop valid.
  always_comb begin
    imm_d     = imm_q;
    fmt_d     = fmt_q;
    illegal_d = illegal_q;
    vld_d     = vld_q;
    if (flush) begin
      imm_d     = '0;
      fmt_d     = FMT_R;
      illegal_d = 1'b0;
      vld_d     = 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        imm_d     = dec_imm;
        fmt_d     = dec_fmt;
        illegal_d = dec_illegal;
        vld_d     = 1'b1;
      end else begin
        vld_d     = 1'b0;
      end
    end
  end

  // ID/EX boundary register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_q     <= '0;
      fmt_q     <= FMT_R;
      illegal_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      imm_q     <= imm_d;
      fmt_q     <= fmt_d;
      illegal_q <= illegal_d;
      vld_q     <= vld_d;
    end
  end

  assign imm       = imm_q;
  assign imm_fmt   = fmt_q;
  assign illegal   = illegal_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance driven in
// parallel, compared every cycle against an arithmetic reference model, plus
// literal expectations for the hand-decoded instructions.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        ill32, vld32;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic        ill64, vld64;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // Reference state
  logic [63:0] e_imm = '0;
  logic [2:0]  e_fmt = '0;
  logic        e_ill = 1'b0;
  logic        e_vld = 1'b0;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
    .stall(stall), .flush(flush),
    .imm(imm32), .imm_fmt(fmt32), .illegal(ill32), .out_valid(vld32)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
    .stall(stall), .flush(flush),
    .imm(imm64), .imm_fmt(fmt64), .illegal(ill64), .out_valid(vld64)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate value as the ISA defines it: weighted sum of instruction bits,
  // with instr[31] carrying the negative weight of the field's top bit.
  function automatic void model_dec(input logic [31:0] w, output logic [63:0] v,
                                    output logic [2:0] f, output logic il);
    longint s;
    longint t;
    t  = w[31] ? 64'sd1 : 64'sd0;
    s  = 0;
    il = 1'b0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: begin
        s = -2048 * t + longint'(w[30:20]); f = 3'd1;
      end
      7'h23: begin
        s = -2048 * t + longint'(w[30:25]) * 32 + longint'(w[11:7]); f = 3'd2;
      end
      7'h63: begin
        s = -4096 * t + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
            + longint'(w[11:8]) * 2;
        f = 3'd3;
      end
      7'h37, 7'h17: begin
        s = -(64'sd2147483648) * t + longint'(w[30:12]) * 4096; f = 3'd4;
      end
      7'h6F: begin
        s = -(64'sd1048576) * t + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
            + longint'(w[30:21]) * 2;
        f = 3'd5;
      end
      7'h73: begin
        if (w[14]) begin
          s = longint'(w[19:15]); f = 3'd6;
        end else begin
          s = -2048 * t + longint'(w[30:20]); f = 3'd1;
        end
      end
      7'h33: begin
        s = 0; f = 3'd0;
      end
      default: begin
        s = 0; f = 3'd7; il = 1'b1;
      end
    endcase
    v = s;
  endfunction

  // Reference pipeline register: what the outputs must hold after each edge.
  always @(posedge clk or posedge reset) begin
    logic [63:0] v;
    logic [2:0]  f;
    logic        il;
    if (reset || flush) begin
      e_imm = '0; e_fmt = 3'd0; e_ill = 1'b0; e_vld = 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        model_dec(instr, v, f, il);
        e_imm = v; e_fmt = f; e_ill = il; e_vld = 1'b1;
      end else begin
        e_vld = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("imm32", {32'b0, imm32}, {32'b0, e_imm[31:0]});
      check("fmt32", {61'b0, fmt32}, {61'b0, e_fmt});
      check("ill32", {63'b0, ill32}, {63'b0, e_ill});
      check("vld32", {63'b0, vld32}, {63'b0, e_vld});
      check("imm64", imm64, e_imm);
      check("fmt64", {61'b0, fmt64}, {61'b0, e_fmt});
      check("ill64", {63'b0, ill64}, {63'b0, e_ill});
      check("vld64", {63'b0, vld64}, {63'b0, e_vld});
    end
  end

  task automatic drive(input logic [31:0] w, input logic v, input logic s, input logic f);
    instr = w; in_valid = v; stall = s; flush = f;
    @(negedge clk);
  endtask

  localparam logic [31:0] ADDI_M1 = 32'hFFF00093;
  localparam logic [31:0] SW_M4   = 32'hFE112E23;
  localparam logic [31:0] BEQ_M8  = 32'hFE000CE3;
  localparam logic [31:0] LUI_HI  = 32'h800002B7;
  localparam logic [31:0] CSRRWI  = 32'h300FD073;
  localparam logic [31:0] BAD_OPC = 32'h0000007F;
  localparam logic [31:0] ADD_R   = 32'h002081B3;
  localparam logic [31:0] JAL_M4  = 32'hFFDFF06F;

  logic [6:0] opc_tab [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                               7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F, 7'h0B};

  initial begin
    logic [31:0] r;
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_imm", {32'b0, imm32}, 64'h0);
    check("rst_fmt", {61'b0, fmt32}, 64'h0);
    check("rst_vld", {63'b0, vld64}, 64'h0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Basic decodes with hand-computed values
    drive(ADDI_M1, 1, 0, 0);
    check("addi_imm", {32'b0, imm32}, 64'hFFFF_FFFF);
    check("addi_fmt", {61'b0, fmt32}, 64'd1);
    check("addi_vld", {63'b0, vld32}, 64'd1);
    drive(SW_M4, 1, 0, 0);
    check("sw_imm", {32'b0, imm32}, 64'hFFFF_FFFC);
    check("sw_fmt", {61'b0, fmt32}, 64'd2);
    drive(BEQ_M8, 1, 0, 0);
    check("beq_imm", {32'b0, imm32}, 64'hFFFF_FFF8);
    check("beq_fmt", {61'b0, fmt32}, 64'd3);
    drive(LUI_HI, 1, 0, 0);
    check("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    check("lui_imm32", {32'b0, imm32}, 64'h8000_0000);
    drive(CSRRWI, 1, 0, 0);
    check("csri_imm64", imm64, 64'h1F);
    check("csri_fmt", {61'b0, fmt64}, 64'd6);
    drive(BAD_OPC, 1, 0, 0);
    check("x_fmt", {61'b0, fmt32}, 64'd7);
    check("x_ill", {63'b0, ill32}, 64'd1);
    check("x_vld", {63'b0, vld32}, 64'd1);
    drive(ADD_R, 1, 0, 0);
    check("r_fmt", {61'b0, fmt32}, 64'd0);
    check("r_ill", {63'b0, ill32}, 64'd0);
    drive(JAL_M4, 1, 0, 0);
    check("jal_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    // Bubble: valid drops, payload holds
    drive(ADD_R, 0, 0, 0);
    check("bub_vld", {63'b0, vld32}, 64'd0);
    check("bub_imm", {32'b0, imm32}, 64'hFFFF_FFFC);

    // Stall holds for three cycles, release loads the waiting word
    drive(ADDI_M1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(SW_M4, 1, 1, 0);
      check("stall_imm", {32'b0, imm32}, 64'hFFFF_FFFF);
      check("stall_fmt", {61'b0, fmt32}, 64'd1);
    end
    drive(SW_M4, 1, 0, 0);
    check("rel_imm", {32'b0, imm32}, 64'hFFFF_FFFC);
    check("rel_fmt", {61'b0, fmt32}, 64'd2);
    // Flush wins over stall, and repeats while held
    for (int i = 0; i < 3; i++) begin
      drive(BEQ_M8, 1, 1, 1);
      check("flush_vld", {63'b0, vld32}, 64'd0);
      check("flush_imm", {32'b0, imm32}, 64'd0);
    end

    // Asynchronous reset between edges
    drive(ADDI_M1, 1, 0, 0);
    check("pre_rst_vld", {63'b0, vld32}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_vld", {63'b0, vld32}, 64'd0);
    check("async_imm", {32'b0, imm32}, 64'd0);
    check("async_imm64", imm64, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(ADD_R, 1, 0, 0);
    check("post_rst_vld", {63'b0, vld32}, 64'd1);

    // Mixed traffic over every opcode class with random fields
    for (int i = 0; i < 200; i++) begin
      r = $urandom();
      drive({r[31:7], opc_tab[$urandom_range(0, 11)]},
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 7) == 0));
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
